// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and window helpers for the scan timing
// generator and the object renderers that consume its poll coordinates.
package vga_timing_pkg;

    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam bit DEF_SYNC_POL = 1'b0;

    localparam int H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int HS_END   = HS_START + DEF_H_SYNC - 1;
    localparam int VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int VS_END   = VS_START + DEF_V_SYNC - 1;

    // Inclusive range test on a 10-bit raster counter.
    function automatic logic inWindow(input logic [9:0] val, input int lo, input int hi);
        return (int'(val) >= lo) && (int'(val) <= hi);
    endfunction

endpackage

// File: rtl/vga_scan_timing_pixel_strobe.sv
// Divide-by-CLK_DIV counter; pix_en marks the last system clock of each pixel.
module pixel_strobe #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic pix_en
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0] divCnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divCnt <= '0;
        end else begin
            divCnt <= (divCnt == DIV_LAST) ? 4'd0 : divCnt + 4'd1;
        end
    end

    // With CLK_DIV=1 the counter never leaves 0, so the strobe is constant.
    assign pix_en = (divCnt == DIV_LAST);

endmodule

// File: rtl/vga_scan_timing.sv
// VGA raster timing: h/v counters, sync/blank decode and registered poll coordinates.
// Outputs are decoded from the next-state counters so they line up with hCnt/vCnt.
module vga_scan_timing
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = DEF_SYNC_POL
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] PollX,
    output logic [8:0] PollY,
    output logic       line_tick,
    output logic       frame_tick
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_LO = H_ACTIVE + H_FP;
    localparam int HS_HI = HS_LO + H_SYNC - 1;
    localparam int VS_LO = V_ACTIVE + V_FP;
    localparam int VS_HI = VS_LO + V_SYNC - 1;

    localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);

    generate
        if (H_TOT > 1024 || V_TOT > 1024) begin : gBadTotal
            $error("vga_scan_timing: H_TOTAL=%0d / V_TOTAL=%0d exceed 10-bit counters", H_TOT, V_TOT);
        end
        if (CLK_DIV < 1 || CLK_DIV > 16) begin : gBadDiv
            $error("vga_scan_timing: CLK_DIV=%0d outside 1..16", CLK_DIV);
        end
    endgenerate

    pixel_strobe #(
        .CLK_DIV(CLK_DIV)
    ) uStrobe (
        .clk   (clk),
        .reset (reset),
        .pix_en(pix_en)
    );

    logic [9:0] hCnt;
    logic [9:0] vCnt;
    logic [9:0] hNext;
    logic [9:0] vNext;
    logic       hWrap;
    logic       vWrap;
    logic       activeNext;

    always_comb begin
        hWrap = pix_en && (hCnt == H_LAST);
        vWrap = hWrap && (vCnt == V_LAST);
        hNext = hCnt;
        vNext = vCnt;
        if (pix_en) begin
            hNext = hWrap ? 10'd0 : hCnt + 10'd1;
            if (hWrap) begin
                vNext = vWrap ? 10'd0 : vCnt + 10'd1;
            end
        end
        activeNext = (hNext < H_VIS) && (vNext < V_VIS);
    end

    // Counter and output register stage; the decode is reloaded every clock so the
    // first edge after reset release already presents pixel (0,0).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hCnt       <= '0;
            vCnt       <= '0;
            hsync      <= ~SYNC_POL;
            vsync      <= ~SYNC_POL;
            video_on   <= 1'b0;
            PollX      <= '0;
            PollY      <= '0;
            line_tick  <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            hCnt       <= hNext;
            vCnt       <= vNext;
            hsync      <= inWindow(hNext, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
            vsync      <= inWindow(vNext, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
            video_on   <= activeNext;
            PollX      <= activeNext ? hNext : 10'd0;
            PollY      <= activeNext ? vNext[8:0] : 9'd0;
            line_tick  <= hWrap;
            frame_tick <= vWrap;
        end
    end

endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing: a reduced-raster instance for frame-level behaviour
// and a default 640x480 instance for line-level timing and mid-line reset.
module tb_vga_scan_timing;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic resetS, resetD;

    logic       pixEnS, hsyncS, vsyncS, videoOnS, lineTickS, frameTickS;
    logic [9:0] PollXS;
    logic [8:0] PollYS;
    logic       pixEnD, hsyncD, vsyncD, videoOnD, lineTickD, frameTickD;
    logic [9:0] PollXD;
    logic [8:0] PollYD;

    // Small raster: 16 pixels x 10 lines, hsync at h 10..12, vsync at v 7..8, active-high syncs.
    vga_scan_timing #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
    ) dutS (
        .clk(clk), .reset(resetS), .pix_en(pixEnS), .hsync(hsyncS), .vsync(vsyncS),
        .video_on(videoOnS), .PollX(PollXS), .PollY(PollYS),
        .line_tick(lineTickS), .frame_tick(frameTickS)
    );

    vga_scan_timing dutD (
        .clk(clk), .reset(resetD), .pix_en(pixEnD), .hsync(hsyncD), .vsync(vsyncD),
        .video_on(videoOnD), .PollX(PollXD), .PollY(PollYD),
        .line_tick(lineTickD), .frame_tick(frameTickD)
    );

    typedef struct {
        int         n;
        logic       hs;
        logic       vs;
        logic       von;
        logic [9:0] px;
        logic [8:0] py;
        logic       lt;
        logic       ft;
    } vec_t;

    vec_t vecs[15];

    int passed = 0;
    int total  = 0;
    int curEdge, target, cnt, guard, per;
    int accFt, accLt, accVon, accVs, accHs, accPix;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    initial begin
        // n = pixel index h + 16*v since release (n >= 16*10 is the next frame)
        vecs[0]  = '{0,   1'b0, 1'b0, 1'b1, 10'd0, 9'd0, 1'b0, 1'b0};
        vecs[1]  = '{7,   1'b0, 1'b0, 1'b1, 10'd7, 9'd0, 1'b0, 1'b0};
        vecs[2]  = '{8,   1'b0, 1'b0, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0};
        vecs[3]  = '{10,  1'b1, 1'b0, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0};
        vecs[4]  = '{12,  1'b1, 1'b0, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0};
        vecs[5]  = '{13,  1'b0, 1'b0, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0};
        vecs[6]  = '{16,  1'b0, 1'b0, 1'b1, 10'd0, 9'd1, 1'b1, 1'b0};
        vecs[7]  = '{17,  1'b0, 1'b0, 1'b1, 10'd1, 9'd1, 1'b0, 1'b0};
        vecs[8]  = '{85,  1'b0, 1'b0, 1'b1, 10'd5, 9'd5, 1'b0, 1'b0};
        vecs[9]  = '{96,  1'b0, 1'b0, 1'b0, 10'd0, 9'd0, 1'b1, 1'b0};
        vecs[10] = '{115, 1'b0, 1'b1, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0};
        vecs[11] = '{139, 1'b1, 1'b1, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0};
        vecs[12] = '{159, 1'b0, 1'b0, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0};
        vecs[13] = '{160, 1'b0, 1'b0, 1'b1, 10'd0, 9'd0, 1'b1, 1'b1};
        vecs[14] = '{166, 1'b0, 1'b0, 1'b1, 10'd6, 9'd0, 1'b0, 1'b0};

        resetS = 1'b0;
        resetD = 1'b0;
        @(negedge clk);
        check("rstS pix_en",   32'(pixEnS),   0);
        check("rstS hsync",    32'(hsyncS),   0);
        check("rstS vsync",    32'(vsyncS),   0);
        check("rstS video_on", 32'(videoOnS), 0);
        check("rstD pix_en",   32'(pixEnD),   0);
        check("rstD hsync",    32'(hsyncD),   1);
        check("rstD vsync",    32'(vsyncD),   1);
        check("rstD video_on", 32'(videoOnD), 0);
        check("rstD PollX",    32'(PollXD),   0);
        check("rstD PollY",    32'(PollYD),   0);
        check("rstD ticks",    32'({lineTickD, frameTickD}), 0);

        // Small raster, table-driven. State n is reached on edge 2n after release (edge 1 for n=0).
        resetS  = 1'b1;
        curEdge = 0;
        for (int i = 0; i < 15; i++) begin
            target = (vecs[i].n == 0) ? 1 : 2 * vecs[i].n;
            repeat (target - curEdge) @(negedge clk);
            curEdge = target;
            check($sformatf("vec%0d hsync", i),      32'(hsyncS),     32'(vecs[i].hs));
            check($sformatf("vec%0d vsync", i),      32'(vsyncS),     32'(vecs[i].vs));
            check($sformatf("vec%0d video_on", i),   32'(videoOnS),   32'(vecs[i].von));
            check($sformatf("vec%0d PollX", i),      32'(PollXS),     32'(vecs[i].px));
            check($sformatf("vec%0d PollY", i),      32'(PollYS),     32'(vecs[i].py));
            check($sformatf("vec%0d line_tick", i),  32'(lineTickS),  32'(vecs[i].lt));
            check($sformatf("vec%0d frame_tick", i), 32'(frameTickS), 32'(vecs[i].ft));
        end

        // Whole small frame: 160 pixels = 320 clocks starting at a frame tick.
        guard = 0;
        while (!frameTickS && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("small frame tick seen", 32'(frameTickS), 1);
        accFt = 0; accLt = 0; accVon = 0; accVs = 0; accHs = 0;
        for (int c = 0; c < 320; c++) begin
            accFt  += int'(frameTickS);
            accLt  += int'(lineTickS);
            accVon += int'(pixEnS && videoOnS);
            accVs  += int'(vsyncS);
            accHs  += int'(hsyncS);
            @(negedge clk);
        end
        check("small frame_tick per frame", accFt, 1);
        check("small line_tick per frame",  accLt, 10);
        check("small video_on pixels",      accVon, 48);
        check("small vsync clocks",         accVs, 64);
        check("small hsync clocks",         accHs, 60);
        check("small frame_tick period",    32'(frameTickS), 1);
        @(negedge clk);
        check("small tick one clk",         32'({lineTickS, frameTickS}), 0);
        check("small after wrap video_on",  32'(videoOnS), 1);

        // Default 640x480, CLK_DIV=4.
        resetD = 1'b1;
        @(negedge clk);
        check("first pixel video_on", 32'(videoOnD), 1);
        check("first pixel PollX",    32'(PollXD),   0);
        check("first pixel PollY",    32'(PollYD),   0);
        check("first pixel hsync",    32'(hsyncD),   1);
        check("first pixel ticks",    32'({lineTickD, frameTickD}), 0);

        cnt = 0; guard = 0;
        while (PollXD != 10'd639 && guard < 4000) begin
            if (pixEnD) cnt++;
            @(negedge clk);
            guard++;
        end
        check("pix_en to PollX 639", cnt, 639);
        check("video_on at 639",     32'(videoOnD), 1);

        guard = 0;
        while (!pixEnD && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        per = 1;
        while (!pixEnD && per < 20) begin
            @(negedge clk);
            per++;
        end
        check("pix_en period", per, 4);
        check("h640 video_on", 32'(videoOnD), 0);
        check("h640 PollX",    32'(PollXD),   0);

        cnt = 0; guard = 0;
        while (hsyncD && guard < 200) begin
            if (pixEnD) cnt++;
            @(negedge clk);
            guard++;
        end
        check("pix_en 640 to hsync start", cnt, 16);
        per = 0; accPix = 0;
        while (!hsyncD && per < 1000) begin
            accPix += int'(pixEnD);
            @(negedge clk);
            per++;
        end
        check("hsync low clocks",  per, 384);
        check("hsync low pix_en",  accPix, 96);

        guard = 0;
        while (!lineTickD && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("line_tick seen",     32'(lineTickD), 1);
        check("line 1 PollY",       32'(PollYD), 1);
        check("line wrap PollX",    32'(PollXD), 0);
        check("line 1 frame_tick",  32'(frameTickD), 0);
        @(negedge clk);
        per = 1;
        while (!lineTickD && per < 4000) begin
            @(negedge clk);
            per++;
        end
        check("line_tick period", per, 3200);
        check("line 2 PollY",     32'(PollYD), 2);

        // Walk to h=700 inside hsync, then reset mid-pulse.
        guard = 0;
        while (hsyncD && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        cnt = 0; guard = 0;
        while (cnt < 44 && guard < 400) begin
            if (pixEnD) cnt++;
            @(negedge clk);
            guard++;
        end
        check("hsync asserted at 700", 32'(hsyncD), 0);
        #2 resetD = 1'b0;
        #1;
        check("midreset hsync",    32'(hsyncD),   1);
        check("midreset vsync",    32'(vsyncD),   1);
        check("midreset video_on", 32'(videoOnD), 0);
        check("midreset PollY",    32'(PollYD),   0);
        accLt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            accLt += int'(lineTickD || frameTickD || pixEnD);
        end
        check("midreset quiet", accLt, 0);
        resetD = 1'b1;
        @(negedge clk);
        check("restart video_on", 32'(videoOnD), 1);
        check("restart PollX",    32'(PollXD),   0);
        check("restart PollY",    32'(PollYD),   0);
        check("restart tick",     32'(lineTickD), 0);
        per = 1;
        while (!lineTickD && per < 4000) begin
            @(negedge clk);
            per++;
        end
        check("restart first line_tick", per, 3200);
        check("restart line 1 PollY",    32'(PollYD), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
